pc_sequencer: RTL and testbench

- Multicycle PC-update controller. It sequences fetch, decode, execute and exception phases, and drives the 4-bit selector and write enables of the PC-source mux and PC register.
- Mux selector encoding: 0 = ALU result (PC+4), 1 = ALUOut (branch target), 2 = jump target, 3 = register/vector path. Codes 4..15 are never driven.
- Sits beside the main control unit. The main unit reports execute completion and exceptions; this block alone owns pc_write.

---
 rtl/pc_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Multicycle PC-update controller: sequences FETCH/DECODE/EXEC/WB/EXC and owns
// the PC-source selector plus PC, IR and EPC write enables. All outputs registered.
module pc_sequencer #(
   parameter int EXC_LAT = 2,
   parameter int SEL_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_ready,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             overflow,
   input  logic             illegal_op,
   input  logic             exec_done,
   output logic [SEL_W-1:0] pcsource_sel,
   output logic             pc_write,
   output logic             ir_write,
   output logic             epc_write,
   output logic             vec_sel,
   output logic [1:0]       exc_cause,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      WB     = 3'd3,
      EXC    = 3'd4
   } state_t;

   localparam logic [SEL_W-1:0] SEL_PC4  = SEL_W'(0);
   localparam logic [SEL_W-1:0] SEL_BR   = SEL_W'(1);
   localparam logic [SEL_W-1:0] SEL_JMP  = SEL_W'(2);
   localparam logic [SEL_W-1:0] SEL_REG  = SEL_W'(3);
   localparam logic [3:0]       CNT_LAST = 4'(EXC_LAT - 1);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] FN_JR    = 6'h08;

   state_t           state, state_n;
   logic [3:0]       cnt, cnt_n;
   logic             pc_write_n, ir_write_n, epc_write_n, vec_sel_n;
   logic [SEL_W-1:0] sel_n;
   logic [1:0]       cause_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= FETCH;
         cnt          <= '0;
         pc_write     <= 1'b0;
         ir_write     <= 1'b0;
         epc_write    <= 1'b0;
         vec_sel      <= 1'b0;
         pcsource_sel <= SEL_PC4;
         exc_cause    <= 2'b00;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         pc_write     <= pc_write_n;
         ir_write     <= ir_write_n;
         epc_write    <= epc_write_n;
         vec_sel      <= vec_sel_n;
         pcsource_sel <= sel_n;
         exc_cause    <= cause_n;
      end
   end

   // A redirecting state first registers its write pulse, then leaves while the
   // pulse is visible; the registered pc_write doubles as the "pulse issued" flag.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      pc_write_n  = 1'b0;
      ir_write_n  = 1'b0;
      epc_write_n = 1'b0;
      vec_sel_n   = 1'b0;
      sel_n       = SEL_PC4;
      cause_n     = exc_cause;
      case (state)
         FETCH: begin
            if (pc_write) begin
               state_n = DECODE;
            end else if (mem_ready) begin
               pc_write_n = 1'b1;
               ir_write_n = 1'b1;
               cause_n    = 2'b00;
            end
         end
         DECODE: begin
            if (illegal_op) begin
               state_n     = EXC;
               cause_n     = 2'b01;
               epc_write_n = 1'b1;
               vec_sel_n   = 1'b1;
               cnt_n       = '0;
            end else begin
               state_n = EXEC;
            end
         end
         EXEC: begin
            if (pc_write) begin
               state_n = FETCH;
            end else begin
               case (opcode)
                  OP_BEQ, OP_BNE: begin
                     if (zero == (opcode == OP_BEQ)) begin
                        pc_write_n = 1'b1;
                        sel_n      = SEL_BR;
                     end else begin
                        state_n = FETCH;
                     end
                  end
                  OP_J, OP_JAL: begin
                     pc_write_n = 1'b1;
                     sel_n      = SEL_JMP;
                  end
                  OP_RTYPE: begin
                     if (funct == FN_JR) begin
                        pc_write_n = 1'b1;
                        sel_n      = SEL_REG;
                     end else begin
                        state_n = WB;
                     end
                  end
                  default: state_n = WB;
               endcase
            end
         end
         WB: begin
            if (overflow) begin
               state_n     = EXC;
               cause_n     = 2'b10;
               epc_write_n = 1'b1;
               vec_sel_n   = 1'b1;
               cnt_n       = '0;
            end else if (exec_done) begin
               state_n = FETCH;
            end
         end
         EXC: begin
            if (pc_write) begin
               state_n = FETCH;
            end else if (cnt == CNT_LAST) begin
               pc_write_n = 1'b1;
               sel_n      = SEL_REG;
               vec_sel_n  = 1'b1;
            end else begin
               cnt_n     = cnt + 4'd1;
               vec_sel_n = 1'b1;
            end
         end
         default: state_n = FETCH;
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (EXC_LAT=2): inputs change 1 time unit after
// each rising edge, outputs are checked at the same point.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       mem_ready;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       overflow;
   logic       illegal_op;
   logic       exec_done;
   logic [3:0] pcsource_sel;
   logic       pc_write;
   logic       ir_write;
   logic       epc_write;
   logic       vec_sel;
   logic [1:0] exc_cause;
   logic [2:0] state_o;

   int total = 0;
   int bad   = 0;

   pc_sequencer #(.EXC_LAT(2), .SEL_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_ready    (mem_ready),
      .opcode       (opcode),
      .funct        (funct),
      .zero         (zero),
      .overflow     (overflow),
      .illegal_op   (illegal_op),
      .exec_done    (exec_done),
      .pcsource_sel (pcsource_sel),
      .pc_write     (pc_write),
      .ir_write     (ir_write),
      .epc_write    (epc_write),
      .vec_sel      (vec_sel),
      .exc_cause    (exc_cause),
      .state_o      (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Snapshot of {state, pc_write, ir_write, epc_write, vec_sel, sel, cause}
   task automatic chk_all(input string tag, input logic [2:0] st, input logic pcw,
                          input logic irw, input logic epcw, input logic vs,
                          input logic [3:0] sel, input logic [1:0] cause);
      chk({tag, ".state"}, 32'(state_o), 32'(st));
      chk({tag, ".pcw"},   32'(pc_write), 32'(pcw));
      chk({tag, ".irw"},   32'(ir_write), 32'(irw));
      chk({tag, ".epcw"},  32'(epc_write), 32'(epcw));
      chk({tag, ".vec"},   32'(vec_sel), 32'(vs));
      chk({tag, ".sel"},   32'(pcsource_sel), 32'(sel));
      chk({tag, ".cause"}, 32'(exc_cause), 32'(cause));
   endtask

   // FETCH handshake ending in the DECODE cycle with opcode/funct presented.
   task automatic fetch_to_decode(input string tag, input logic [1:0] cause_before,
                                  input logic [5:0] op, input logic [5:0] fn);
      mem_ready = 1'b1;
      tick(1);
      mem_ready = 1'b0;
      chk_all({tag, ".fpulse"}, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
      tick(1);
      chk_all({tag, ".dec"}, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, cause_before);
      opcode = op;
      funct  = fn;
   endtask

   initial begin
      reset = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
      overflow = 1'b0; illegal_op = 1'b0; exec_done = 1'b0;
      tick(2);
      chk_all("rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00);
      reset = 1'b0;

      // Idle FETCH, then mem_ready in one cycle -> pulse next cycle, DECODE after.
      tick(2);
      chk_all("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00);

      // beq taken
      fetch_to_decode("beq1", 2'b00, 6'h04, 6'h00);
      zero = 1'b1;
      tick(1);
      chk_all("beq1.exec", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00);
      overflow = 1'b1;
      tick(1);
      chk_all("beq1.pw", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 2'b00);
      overflow = 1'b0;
      tick(1);
      chk_all("beq1.back", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00);

      // beq not taken
      fetch_to_decode("beq0", 2'b00, 6'h04, 6'h00);
      zero = 1'b0;
      tick(1);
      chk("beq0.exec", 32'(state_o), 32'd2);
      tick(1);
      chk_all("beq0.back", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00);

      // bne taken with zero=0
      fetch_to_decode("bne", 2'b00, 6'h05, 6'h00);
      tick(2);
      chk_all("bne.pw", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 2'b00);
      tick(1);

      // jr
      fetch_to_decode("jr", 2'b00, 6'h00, 6'h08);
      tick(2);
      chk_all("jr.pw", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 2'b00);
      tick(1);
      chk("jr.back", 32'(state_o), 32'd0);

      // jal
      fetch_to_decode("jal", 2'b00, 6'h03, 6'h00);
      tick(2);
      chk_all("jal.pw", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 2'b00);
      tick(1);

      // illegal opcode -> EXC, EXC_LAT=2
      fetch_to_decode("ill", 2'b00, 6'h3f, 6'h00);
      illegal_op = 1'b1;
      tick(1);
      chk_all("ill.e0", 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 2'b01);
      overflow = 1'b1;
      tick(1);
      chk_all("ill.e1", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 2'b01);
      tick(1);
      chk_all("ill.e2", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 2'b01);
      illegal_op = 1'b0;
      overflow   = 1'b0;
      tick(1);
      chk_all("ill.back", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b01);

      // cause cleared by the next FETCH write; add with overflow+exec_done in WB
      fetch_to_decode("ovf", 2'b00, 6'h00, 6'h20);
      tick(1);
      chk("ovf.exec", 32'(state_o), 32'd2);
      tick(1);
      chk_all("ovf.wb", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00);
      overflow  = 1'b1;
      exec_done = 1'b1;
      tick(1);
      chk_all("ovf.e0", 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 2'b10);
      overflow  = 1'b0;
      exec_done = 1'b0;
      tick(2);
      chk_all("ovf.e2", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 2'b10);
      tick(1);

      // WB holds without exec_done, leaves on exec_done
      fetch_to_decode("wb", 2'b00, 6'h23, 6'h00);
      tick(2);
      chk("wb.in", 32'(state_o), 32'd3);
      tick(3);
      chk_all("wb.hold", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00);
      exec_done = 1'b1;
      tick(1);
      exec_done = 1'b0;
      chk_all("wb.done", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00);

      // reset in EXC with counter at 1
      fetch_to_decode("rexc", 2'b00, 6'h3f, 6'h00);
      illegal_op = 1'b1;
      tick(1);
      illegal_op = 1'b0;
      chk("rexc.e0", 32'(epc_write), 32'd1);
      tick(1);
      chk("rexc.e1", 32'(state_o), 32'd4);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk_all("rexc.rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00);
      tick(1);
      chk_all("rexc.after1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00);
      tick(1);
      chk_all("rexc.after2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
